mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter: RUN_CYCLES, 32, number of clocks the multiplier core is given to compute (legal 1..63).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: signed_op  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port: operand_a  input  32  multiplicand from register bus.
REQ-007 SHALL have port: operand_b  input  32  multiplier from register bus.
REQ-008 SHALL have port: mul_mcand  output  32  magnitude of A driven to core.
REQ-009 SHALL have port: mul_mplier  output  32  magnitude of B driven to core.
REQ-010 SHALL have port: mul_rst_n  output  1  active-low load strobe to core.
REQ-011 SHALL have port: mul_product  input  64  unsigned product returned by core.
REQ-012 SHALL have port: busy  output  1  high in LOAD, RUN, CAPTURE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: hi  output  32  upper product word (HI register).
REQ-015 SHALL have port: lo  output  32  lower product word (LO register).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, CAPTURE, DONE.
REQ-017 IDLE: start=1 at an edge SHALL latch operands and signed_op and move to LOAD; start=0 stays IDLE.
REQ-018 Latch SHALL store mul_mcand/mul_mplier as |operand| when signed_op=1 (0x80000000 stays 0x80000000 as unsigned), raw operand otherwise, and neg_flag = signed_op & (a[31] ^ b[31]).
REQ-019 LOAD: mul_rst_n SHALL be 0 for exactly this one cycle; 6-bit cycle counter cleared; next state RUN.
REQ-020 RUN: mul_rst_n=1; counter increments each cycle; at counter == RUN_CYCLES-1 next state CAPTURE.
REQ-021 CAPTURE: {hi,lo} SHALL load mul_product, or its 64-bit two's-complement negation when neg_flag=1; next state DONE.
REQ-022 DONE: done=1 for this cycle only, busy=0; next state IDLE unconditionally.
REQ-023 start in any state other than IDLE SHALL be ignored (no queuing); operand/flag latches SHALL hold through the operation.
REQ-024 Latency: start accepted at edge N SHALL give done=1 in cycle N+RUN_CYCLES+3, hi/lo valid from that cycle.
REQ-025 hi/lo SHALL hold their value until the next CAPTURE; they change only in CAPTURE or on reset.
REQ-026 mul_mcand/mul_mplier SHALL stay stable from LOAD through CAPTURE.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, latches=0, mul_rst_n=0, regardless of state (mid-RUN included).
REQ-028 mul_rst_n SHALL be 0 while rst=1 and in LOAD, 1 otherwise.
REQ-029 After rst deasserts, first start SHALL behave exactly as REQ-017..REQ-024; an aborted operation SHALL produce no done pulse.

Verification (bench uses behavioural core model: mul_product = mcand*mplier from RUN_CYCLES clocks after load, RUN_CYCLES=32)
REQ-030 Unsigned 3 x 5 -> busy high 34 cycles, done at N+35, hi=0x00000000, lo=0x0000000F.
REQ-031 Signed 0xFFFFFFFE x 3 -> mul_mcand=2, mul_mplier=3, {hi,lo}=0xFFFFFFFF_FFFFFFFA.
REQ-032 Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Second start (7 x 7) pulsed during RUN of 3 x 5 -> ignored; single done, lo=0x0000000F.
REQ-034 rst asserted at RUN cycle 10 of 4 x 4 -> same instant busy=0, hi=lo=0, mul_rst_n=0; no done pulse follows.
REQ-035 Back-to-back: start held high through DONE -> new op accepted in following IDLE cycle, previous hi/lo held until its CAPTURE.

Source files
------------

// File: rtl/mult_sequencer.sv
// Sequencer for a multi-cycle unsigned multiplier core: it latches the operands, strobes the core,
// waits RUN_CYCLES clocks, then captures a sign-corrected 64-bit product into HI/LO.
//   state   | meaning
//   IDLE    | waiting for start; operands latched on acceptance
//   LOAD    | core load strobe (mul_rst_n low), cycle counter cleared
//   RUN     | core computing, counter runs to RUN_CYCLES-1
//   CAPTURE | product (negated if result is negative) written to HI/LO
//   DONE    | one-cycle completion pulse
module mult_sequencer #(
  parameter int RUN_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] mul_mcand,
  output logic [31:0] mul_mplier,
  output logic        mul_rst_n,
  input  logic [63:0] mul_product,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

  localparam logic [5:0] LAST_CNT = 6'(RUN_CYCLES - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic        neg_flag;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] product_fix;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (signed_op && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
    mag_b = (signed_op && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;
    product_fix = neg_flag ? (~mul_product + 64'd1) : mul_product;
  end

  // Combinational so the core is held in reset for the whole time rst is high.
  assign mul_rst_n = ~rst & (state != LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      neg_flag   <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mul_mcand  <= mag_a;
            mul_mplier <= mag_b;
            neg_flag   <= signed_op & (operand_a[31] ^ operand_b[31]);
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST_CNT) state <= CAPTURE;
        end
        CAPTURE: begin
          {hi, lo} <= product_fix;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
